p_predict_serial: RTL and testbench

P_PREDICT_SERIAL -- requirements
Module: p_predict_serial

---
 rtl/kf_pkg.sv | 17 +
 rtl/fxp_add.sv | 13 +
 rtl/p_predict_serial.sv | 151 +++++++++++++++
 tb/tb_p_predict_serial.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kf_pkg.sv
// Shared Kalman-filter constants: default word format, FSM state encoding and
// saturation limits for the default word width.
package kf_pkg;

   localparam int KF_N    = 20;
   localparam int KF_FRAC = 10;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_ADD  = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;

   localparam longint KF_SAT_MAX = (longint'(1) <<< (KF_N - 1)) - 1;
   localparam longint KF_SAT_MIN = -(longint'(1) <<< (KF_N - 1));

endpackage

// File: rtl/fxp_add.sv
// Signed fixed-point adder returning the full-precision N+1-bit sum;
// the caller decides how to clamp.
module fxp_add #(
   parameter int N = 20
) (
   input  logic signed [N-1:0] i_a,
   input  logic signed [N-1:0] i_b,
   output logic signed [N:0]   o_sum
);

   assign o_sum = {i_a[N-1], i_a} + {i_b[N-1], i_b};

endmodule

// File: rtl/p_predict_serial.sv
// Serial covariance prediction Pp = F*P*F^T + Q with F = [[1,1],[0,1]],
// evaluated as nine saturating additions through one shared adder.
module p_predict_serial
   import kf_pkg::*;
#(
   parameter int N    = KF_N,
   parameter int FRAC = KF_FRAC,
   parameter int TMO  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic signed [N-1:0] P11,
   input  logic signed [N-1:0] P12,
   input  logic signed [N-1:0] P21,
   input  logic signed [N-1:0] P22,
   output logic                q_start,
   input  logic                q_done,
   input  logic signed [N-1:0] Q11,
   input  logic signed [N-1:0] Q12,
   input  logic signed [N-1:0] Q21,
   input  logic signed [N-1:0] Q22,
   output logic                busy,
   output logic                done,
   output logic                sat,
   output logic                err,
   output logic signed [N-1:0] Pp11,
   output logic signed [N-1:0] Pp12,
   output logic signed [N-1:0] Pp21,
   output logic signed [N-1:0] Pp22
);

   localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
   localparam logic signed [N-1:0] L_MAX = {1'b0, {(N-1){1'b1}}};
   localparam logic signed [N-1:0] L_MIN = {1'b1, {(N-1){1'b0}}};

   generate
      if (FRAC >= N) begin : g_bad_frac
         $error("p_predict_serial: FRAC must be smaller than N");
      end
   endgenerate

   logic [2:0]          r_state;
   logic [TW-1:0]       r_tmo;
   logic [3:0]          r_op;
   logic signed [N-1:0] r_acc;
   logic signed [N-1:0] r_p11, r_p12, r_p21, r_p22;
   logic signed [N-1:0] r_q11, r_q12, r_q21, r_q22;
   logic signed [N-1:0] r_pp11, r_pp12, r_pp21, r_pp22;
   logic                r_sat;
   logic                r_err;

   logic signed [N-1:0] w_a, w_b, w_res;
   logic signed [N:0]   w_sum;
   logic                w_clip;

   // Op schedule: the first op of each output seeds from P, the rest chain on r_acc.
   always_comb begin
      w_a = r_acc;
      w_b = '0;
      case (r_op)
         4'd0: begin w_a = r_p22; w_b = r_q22; end
         4'd1: begin w_a = r_p12; w_b = r_p22; end
         4'd2: w_b = r_q12;
         4'd3: begin w_a = r_p21; w_b = r_p22; end
         4'd4: w_b = r_q21;
         4'd5: begin w_a = r_p11; w_b = r_p12; end
         4'd6: w_b = r_p21;
         4'd7: w_b = r_p22;
         4'd8: w_b = r_q11;
         default: ;
      endcase
   end

   fxp_add #(.N(N)) u_add (
      .i_a   (w_a),
      .i_b   (w_b),
      .o_sum (w_sum)
   );

   // The N+1-bit sum overflows N bits exactly when its top two bits differ.
   assign w_clip = w_sum[N] ^ w_sum[N-1];
   assign w_res  = w_clip ? (w_sum[N] ? L_MIN : L_MAX) : w_sum[N-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_tmo   <= '0;
         r_op    <= '0;
         r_acc   <= '0;
         r_p11   <= '0; r_p12  <= '0; r_p21  <= '0; r_p22  <= '0;
         r_q11   <= '0; r_q12  <= '0; r_q21  <= '0; r_q22  <= '0;
         r_pp11  <= '0; r_pp12 <= '0; r_pp21 <= '0; r_pp22 <= '0;
         r_sat   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_p11   <= P11; r_p12 <= P12; r_p21 <= P21; r_p22 <= P22;
                  r_sat   <= 1'b0;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               r_tmo   <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (q_done) begin
                  r_q11   <= Q11; r_q12 <= Q12; r_q21 <= Q21; r_q22 <= Q22;
                  r_op    <= '0;
                  r_state <= S_ADD;
               end else if (r_tmo == TW'(TMO - 1)) begin
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            S_ADD: begin
               r_acc <= w_res;
               if (w_clip) r_sat <= 1'b1;
               case (r_op)
                  4'd0: r_pp22 <= w_res;
                  4'd2: r_pp12 <= w_res;
                  4'd4: r_pp21 <= w_res;
                  4'd8: r_pp11 <= w_res;
                  default: ;
               endcase
               if (r_op == 4'd8) r_state <= S_FIN;
               else              r_op    <= r_op + 4'd1;
            end
            S_FIN:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign q_start = (r_state == S_REQ);
   assign busy    = (r_state != S_IDLE);
   assign done    = (r_state == S_FIN);
   assign sat     = r_sat;
   assign err     = r_err;
   assign Pp11    = r_pp11;
   assign Pp12    = r_pp12;
   assign Pp21    = r_pp21;
   assign Pp22    = r_pp22;

endmodule

// File: tb/tb_p_predict_serial.sv
// Randomized bench for p_predict_serial: a cycle-indexed model derived from the
// run timeline and saturating arithmetic is checked against the DUT every cycle.
module tb_p_predict_serial;

   localparam int     N    = 20;
   localparam longint MAXV = (longint'(1) <<< (N - 1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (N - 1));

   logic clk = 1'b0;
   logic rst_n, start, q_done;
   logic signed [N-1:0] P11, P12, P21, P22, Q11, Q12, Q21, Q22;
   logic q_start, busy, done, sat, err;
   logic signed [N-1:0] Pp11, Pp12, Pp21, Pp22;

   always #5 clk = ~clk;

   p_predict_serial #(.N(N), .FRAC(10), .TMO(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .P11(P11), .P12(P12), .P21(P21), .P22(P22),
      .q_start(q_start), .q_done(q_done),
      .Q11(Q11), .Q12(Q12), .Q21(Q21), .Q22(Q22),
      .busy(busy), .done(done), .sat(sat), .err(err),
      .Pp11(Pp11), .Pp12(Pp12), .Pp21(Pp21), .Pp22(Pp22)
   );

   int     n_chk  = 0;
   int     n_fail = 0;
   bit     cmp_en = 1'b0;
   bit     exp_qs, exp_busy, exp_done, exp_err, exp_sat, chk_sat;
   longint exp_pp [4];   // index 0:Pp11 1:Pp12 2:Pp21 3:Pp22

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("q_start", longint'(q_start), longint'(exp_qs));
         chk("busy",    longint'(busy),    longint'(exp_busy));
         chk("done",    longint'(done),    longint'(exp_done));
         chk("err",     longint'(err),     longint'(exp_err));
         if (chk_sat) chk("sat", longint'(sat), longint'(exp_sat));
         chk("Pp11", longint'(Pp11), exp_pp[0]);
         chk("Pp12", longint'(Pp12), exp_pp[1]);
         chk("Pp21", longint'(Pp21), exp_pp[2]);
         chk("Pp22", longint'(Pp22), exp_pp[3]);
      end
   end

   function automatic longint sadd(input longint a, input longint b, inout bit s);
      longint r;
      r = a + b;
      if (r > MAXV) begin r = MAXV; s = 1'b1; end
      if (r < MINV) begin r = MINV; s = 1'b1; end
      return r;
   endfunction

   function automatic longint rv();
      if ($urandom_range(0, 3) == 0)
         return longint'($urandom_range(0, (1 << N) - 1)) - (longint'(1) <<< (N - 1));
      return longint'($urandom_range(0, 4095)) - 2048;
   endfunction

   task automatic drive_p(input longint p [4]);
      P11 = N'(p[0]); P12 = N'(p[1]); P21 = N'(p[2]); P22 = N'(p[3]);
   endtask

   task automatic drive_q(input longint q [4]);
      Q11 = N'(q[0]); Q12 = N'(q[1]); Q21 = N'(q[2]); Q22 = N'(q[3]);
   endtask

   task automatic scramble_pq();
      P11 = N'(rv()); P12 = N'(rv()); P21 = N'(rv()); P22 = N'(rv());
      Q11 = N'(rv()); Q12 = N'(rv()); Q21 = N'(rv()); Q22 = N'(rv());
   endtask

   task automatic set_idle_exp();
      exp_qs = 0; exp_busy = 0; exp_done = 0; exp_err = 0; chk_sat = 1;
   endtask

   // Idle cycles with stray q_done and wandering P/Q inputs.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         start  = 1'b0;
         q_done = 1'($urandom_range(0, 1));
         scramble_pq();
         set_idle_exp();
         @(posedge clk); #1;
      end
   endtask

   // One run: start in cycle 0, q_start in cycle 1, WAIT from cycle 2; q_done
   // in cycle k = 2+d (d<0: never), done at k+10 or err at cycle 18.
   // rst_at>0 pulls reset during that cycle; poke_at>0 pulses start then.
   task automatic run(input longint p [4], input longint q [4],
                      input int d, input int rst_at, input int poke_at);
      longint n [4];
      longint a;
      bit     s;
      int     k, last;
      s    = 1'b0;
      n[3] = sadd(p[3], q[3], s);
      a    = sadd(p[1], p[3], s);
      n[1] = sadd(a, q[1], s);
      a    = sadd(p[2], p[3], s);
      n[2] = sadd(a, q[2], s);
      a    = sadd(p[0], p[1], s);
      a    = sadd(a, p[2], s);
      a    = sadd(a, p[3], s);
      n[0] = sadd(a, q[0], s);
      k    = (d < 0) ? -1 : 2 + d;
      last = (d < 0) ? 18 : k + 10;

      start  = 1'b1;
      drive_p(p);
      q_done = 1'($urandom_range(0, 1));
      drive_q('{rv(), rv(), rv(), rv()});
      set_idle_exp();
      @(posedge clk); #1;

      for (int t = 1; t <= last; t++) begin
         start = (t == poke_at) || (t != last && $urandom_range(0, 7) == 0);
         P11 = N'(rv()); P12 = N'(rv()); P21 = N'(rv()); P22 = N'(rv());
         if (t == k) begin
            q_done = 1'b1;
            drive_q(q);
         end else begin
            q_done = (t >= 2 && (k < 0 || t < k)) ? 1'b0 : 1'($urandom_range(0, 1));
            drive_q('{rv(), rv(), rv(), rv()});
         end
         exp_qs   = (t == 1);
         exp_busy = (t < last) || (d >= 0);
         exp_done = (d >= 0) && (t == last);
         exp_err  = (d < 0) && (t == last);
         chk_sat  = (t == last);
         exp_sat  = (d < 0) ? 1'b0 : s;
         if (d >= 0) begin
            if (t == k + 2)  exp_pp[3] = n[3];
            if (t == k + 4)  exp_pp[1] = n[1];
            if (t == k + 6)  exp_pp[2] = n[2];
            if (t == k + 10) exp_pp[0] = n[0];
         end
         if (t == rst_at) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n   = 1'b1;
            start   = 1'b0;
            exp_pp  = '{0, 0, 0, 0};
            exp_sat = 1'b0;
            set_idle_exp();
            return;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      set_idle_exp();
   endtask

   longint p0 [4], q0 [4], pm [4], qm [4], pr [4], qr [4];
   int     d;

   initial begin
      rst_n = 1'b0; start = 1'b0; q_done = 1'b0;
      P11 = '0; P12 = '0; P21 = '0; P22 = '0;
      Q11 = '0; Q12 = '0; Q21 = '0; Q22 = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n   = 1'b1;
      exp_pp  = '{0, 0, 0, 0};
      exp_sat = 1'b0;
      set_idle_exp();
      cmp_en  = 1'b1;
      idle(3);

      // identity-like P, diagonal Q, q_done three cycles after q_start
      p0 = '{1024, 0, 0, 1024};
      q0 = '{256, 0, 0, 256};
      run(p0, q0, 2, 0, 0);
      chk("lit_pp11", longint'(Pp11), 2304);
      chk("lit_pp12", longint'(Pp12), 1024);
      chk("lit_pp21", longint'(Pp21), 1024);
      chk("lit_pp22", longint'(Pp22), 1280);
      chk("lit_sat0", longint'(sat), 0);
      idle(2);

      // positive saturation
      pm = '{MAXV, MAXV, MAXV, MAXV};
      qm = '{1024, 0, 0, 0};
      run(pm, qm, 0, 0, 0);
      chk("lit_satmax_pp11", longint'(Pp11), MAXV);
      chk("lit_sat1", longint'(sat), 1);
      idle(2);

      // timeout: q_done never arrives, outputs hold
      run(p0, q0, -1, 0, 0);
      chk("lit_tmo_pp11", longint'(Pp11), MAXV);
      chk("lit_tmo_busy", longint'(busy), 0);
      idle(2);

      // start pulsed during ADD is ignored
      run(p0, q0, 1, 0, 3 + 4);
      idle(2);

      // reset during ADD, then a clean run
      run(p0, q0, 1, 3 + 5, 0);
      chk("lit_rst_pp11", longint'(Pp11), 0);
      chk("lit_rst_busy", longint'(busy), 0);
      idle(1);
      run(p0, q0, 2, 0, 0);
      chk("lit_rerun_pp11", longint'(Pp11), 2304);
      chk("lit_rerun_pp22", longint'(Pp22), 1280);
      idle(1);

      // negative saturation corner
      pr = '{MINV, MINV, 0, MINV};
      qr = '{-1, -1, 0, 0};
      run(pr, qr, 5, 0, 0);
      chk("lit_satmin_pp11", longint'(Pp11), MINV);
      chk("lit_satmin_pp21", longint'(Pp21), MINV);
      idle(1);

      for (int r = 0; r < 60; r++) begin
         pr = '{rv(), rv(), rv(), rv()};
         qr = '{rv(), rv(), rv(), rv()};
         d  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0 && d >= 0)
            run(pr, qr, d, int'($urandom_range(1, 2 + d + 9)), 0);
         else
            run(pr, qr, d, 0, 0);
         idle(int'($urandom_range(1, 3)));
      end

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
